// File: rtl/fm_pkg.sv
// ---------------------------------------------------------------------------
// fm_pkg
// Shared definitions for the FM phase discriminator:
//   FM_PHASE_WIDTH  default phase word width (2^PW == one full turn)
//   fm_state_t      sample-handling FSM encoding (IDLE, ROT, OUT)
//   quarter_turn()  2^(PW-2), i.e. +pi/2 in phase units
//   atan_lut()      CORDIC angle table, atan(2^-i) in phase units
// ---------------------------------------------------------------------------
package fm_pkg;

  localparam int FM_PHASE_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_OUT  = 2'd2
  } fm_state_t;

  // +pi/2 expressed in a pw-bit phase word.
  function automatic logic [31:0] quarter_turn(input int pw);
    quarter_turn = 32'd1 << (pw - 2);
  endfunction

  // round(atan(2^-i) * 2^pw / (2*pi)). The base table is exact for pw = 16.
  // Other widths are scaled from it, which is exact for the leading entries
  // and within 1 LSB elsewhere. Indices beyond 15 contribute nothing.
  function automatic logic [31:0] atan_lut(input int i, input int pw);
    logic [31:0] v16;
    case (i)
      32'sd0:  v16 = 32'd8192;
      32'sd1:  v16 = 32'd4836;
      32'sd2:  v16 = 32'd2555;
      32'sd3:  v16 = 32'd1297;
      32'sd4:  v16 = 32'd651;
      32'sd5:  v16 = 32'd326;
      32'sd6:  v16 = 32'd163;
      32'sd7:  v16 = 32'd81;
      32'sd8:  v16 = 32'd41;
      32'sd9:  v16 = 32'd20;
      32'sd10: v16 = 32'd10;
      32'sd11: v16 = 32'd5;
      32'sd12: v16 = 32'd3;
      32'sd13: v16 = 32'd1;
      32'sd14: v16 = 32'd1;
      default: v16 = 32'd0;
    endcase
    if (pw >= 16) begin
      atan_lut = v16 << (pw - 16);
    end else begin
      atan_lut = (v16 + (32'd1 << (15 - pw))) >> (16 - pw);
    end
  endfunction

endpackage

// File: rtl/fm_cordic_vec.sv
// ---------------------------------------------------------------------------
// fm_cordic_vec
// Iterative vectoring CORDIC: drives y towards zero one micro-rotation per
// cycle while accumulating the rotated angle in z. The magnitude left in x
// is not used by the discriminator and is not exported.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset (aborts a run)
//   i_start        load i_x/i_y/i_z and begin ITERATIONS micro-rotations
//   i_x, i_y       pre-rotated vector (x >= 0), XW bits signed
//   i_z            starting angle, PHASE_WIDTH bits
//   o_done         high during the cycle of the final micro-rotation
//   o_z            accumulated angle; stable once the run has finished
// ---------------------------------------------------------------------------
module fm_cordic_vec
  import fm_pkg::*;
#(
  parameter int XW          = 18,
  parameter int PHASE_WIDTH = FM_PHASE_WIDTH,
  parameter int ITERATIONS  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_start,
  input  logic signed [XW-1:0]   i_x,
  input  logic signed [XW-1:0]   i_y,
  input  logic [PHASE_WIDTH-1:0] i_z,
  output logic                   o_done,
  output logic [PHASE_WIDTH-1:0] o_z
);

  localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [IW-1:0] LAST_ITER = IW'(ITERATIONS - 1);

  logic signed [XW-1:0]   r_x;
  logic signed [XW-1:0]   r_y;
  logic [PHASE_WIDTH-1:0] r_z;
  logic [IW-1:0]          r_iter;
  logic                   r_busy;

  logic signed [XW-1:0]   w_x_sh;
  logic signed [XW-1:0]   w_y_sh;
  logic [PHASE_WIDTH-1:0] w_atan;

  // Shifted operands and the angle step for the current iteration.
  always_comb begin
    w_x_sh = r_x >>> r_iter;
    w_y_sh = r_y >>> r_iter;
    w_atan = PHASE_WIDTH'(atan_lut(int'(r_iter), PHASE_WIDTH));
  end

  // Load on start, then rotate towards y = 0; all updates use old values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x    <= {XW{1'b0}};
      r_y    <= {XW{1'b0}};
      r_z    <= {PHASE_WIDTH{1'b0}};
      r_iter <= {IW{1'b0}};
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_x    <= i_x;
      r_y    <= i_y;
      r_z    <= i_z;
      r_iter <= {IW{1'b0}};
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (!r_y[XW-1]) begin
        r_x <= r_x + w_y_sh;
        r_y <= r_y - w_x_sh;
        r_z <= r_z + w_atan;
      end else begin
        r_x <= r_x - w_y_sh;
        r_y <= r_y + w_x_sh;
        r_z <= r_z - w_atan;
      end
      if (r_iter == LAST_ITER) begin
        r_busy <= 1'b0;
        r_iter <= {IW{1'b0}};
      end else begin
        r_iter <= r_iter + IW'(1);
      end
    end
  end

  assign o_done = r_busy && (r_iter == LAST_ITER);
  assign o_z    = r_z;

endmodule

// File: rtl/fm_phase_discriminator.sv
// ---------------------------------------------------------------------------
// fm_phase_discriminator
// FM demodulator: measures the phase of each complex baseband sample with a
// vectoring CORDIC and emits the wrapped difference to the previous phase,
// i.e. the instantaneous frequency, as a signed Avalon-ST stream.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   ast_sink_i/_q       signed I/Q input sample
//   ast_sink_valid      1-cycle sample strobe (no backpressure)
//   ast_sink_error      2-bit tag carried with the sample
//   ast_source_data     signed phase delta, pi/2 -> 2^(DATA_WIDTH-2)
//   ast_source_valid    1-cycle output strobe
//   ast_source_error    tag of the sample that produced the output
//   overrun             sticky: a sample arrived while busy and was dropped
// ---------------------------------------------------------------------------
module fm_phase_discriminator
  import fm_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = FM_PHASE_WIDTH,
  parameter int ITERATIONS  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] ast_sink_i,
  input  logic signed [DATA_WIDTH-1:0] ast_sink_q,
  input  logic                         ast_sink_valid,
  input  logic [1:0]                   ast_sink_error,
  output logic signed [DATA_WIDTH-1:0] ast_source_data,
  output logic                         ast_source_valid,
  output logic [1:0]                   ast_source_error,
  output logic                         overrun
);

  // Two guard bits absorb the CORDIC gain (~1.647) on a full-scale diagonal.
  localparam int XW = DATA_WIDTH + 2;

  fm_state_t r_state;
  fm_state_t w_state_nxt;

  logic [1:0]                   r_err_tag;
  logic                         r_zero;
  logic [PHASE_WIDTH-1:0]       r_z_prev;
  logic                         r_primed;
  logic                         r_overrun;
  logic signed [DATA_WIDTH-1:0] r_src_data;
  logic                         r_src_valid;
  logic [1:0]                   r_src_error;

  logic                         w_accept;
  logic                         w_is_zero;
  logic signed [XW-1:0]         w_i_ext;
  logic signed [XW-1:0]         w_q_ext;
  logic signed [XW-1:0]         w_x0;
  logic signed [XW-1:0]         w_y0;
  logic [PHASE_WIDTH-1:0]       w_z0;
  logic [PHASE_WIDTH-1:0]       w_quarter;
  logic                         w_core_done;
  logic [PHASE_WIDTH-1:0]       w_core_z;
  logic [PHASE_WIDTH-1:0]       w_z_cur;
  logic [PHASE_WIDTH-1:0]       w_diff;

  assign w_accept  = (r_state == ST_IDLE) && ast_sink_valid;
  assign w_is_zero = (ast_sink_i == {DATA_WIDTH{1'b0}}) &&
                     (ast_sink_q == {DATA_WIDTH{1'b0}});
  assign w_i_ext   = {{2{ast_sink_i[DATA_WIDTH-1]}}, ast_sink_i};
  assign w_q_ext   = {{2{ast_sink_q[DATA_WIDTH-1]}}, ast_sink_q};
  assign w_quarter = PHASE_WIDTH'(quarter_turn(PHASE_WIDTH));

  // Rotate left-half-plane vectors by +/-pi/2 so the CORDIC starts with x >= 0.
  // Negation is safe: -(-2^(DW-1)) fits in the extended width.
  always_comb begin
    if (!ast_sink_i[DATA_WIDTH-1]) begin
      w_x0 = w_i_ext;
      w_y0 = w_q_ext;
      w_z0 = {PHASE_WIDTH{1'b0}};
    end else if (!ast_sink_q[DATA_WIDTH-1]) begin
      w_x0 = w_q_ext;
      w_y0 = -w_i_ext;
      w_z0 = w_quarter;
    end else begin
      w_x0 = -w_q_ext;
      w_y0 = w_i_ext;
      w_z0 = -w_quarter;
    end
  end

  fm_cordic_vec #(
    .XW          (XW),
    .PHASE_WIDTH (PHASE_WIDTH),
    .ITERATIONS  (ITERATIONS)
  ) u_cordic (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (w_accept),
    .i_x     (w_x0),
    .i_y     (w_y0),
    .i_z     (w_z0),
    .o_done  (w_core_done),
    .o_z     (w_core_z)
  );

  // A zero vector has no defined angle; hold the previous phase instead.
  // The subtraction wraps naturally modulo one full turn.
  always_comb begin
    if (r_zero) begin
      w_z_cur = r_z_prev;
    end else begin
      w_z_cur = w_core_z;
    end
    w_diff = w_z_cur - r_z_prev;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ast_sink_valid) begin
          w_state_nxt = ST_ROT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ROT: begin
        if (w_core_done) begin
          w_state_nxt = ST_OUT;
        end else begin
          w_state_nxt = ST_ROT;
        end
      end
      ST_OUT:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sample capture, phase history, overrun flag and output registers.
  // The first sample after reset only primes the phase history.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err_tag   <= 2'b00;
      r_zero      <= 1'b0;
      r_z_prev    <= {PHASE_WIDTH{1'b0}};
      r_primed    <= 1'b0;
      r_overrun   <= 1'b0;
      r_src_data  <= {DATA_WIDTH{1'b0}};
      r_src_valid <= 1'b0;
      r_src_error <= 2'b00;
    end else begin
      r_src_valid <= 1'b0;
      if (ast_sink_valid && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      if (w_accept) begin
        r_err_tag <= ast_sink_error;
        r_zero    <= w_is_zero;
      end
      if (r_state == ST_OUT) begin
        r_z_prev <= w_z_cur;
        if (r_primed) begin
          r_src_data  <= w_diff[PHASE_WIDTH-1 -: DATA_WIDTH];
          r_src_valid <= 1'b1;
          r_src_error <= r_err_tag;
        end else begin
          r_primed <= 1'b1;
        end
      end
    end
  end

  assign ast_source_data  = r_src_data;
  assign ast_source_valid = r_src_valid;
  assign ast_source_error = r_src_error;
  assign overrun          = r_overrun;

endmodule

// File: tb/tb_fm_phase_discriminator.sv
// ---------------------------------------------------------------------------
// tb_fm_phase_discriminator
// Self-checking bench. The reference model computes the ideal phase of each
// input sample with atan2 and the wrapped difference to the previous sample,
// compared within a small tolerance (circular in the 16-bit phase space).
// ---------------------------------------------------------------------------
module tb_fm_phase_discriminator;

  localparam int  DW = 16;
  localparam int  PW = 16;
  localparam int  N  = 16;
  localparam real PI = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic signed [DW-1:0] sink_i = '0;
  logic signed [DW-1:0] sink_q = '0;
  logic                 sink_valid = 1'b0;
  logic [1:0]           sink_error = 2'b00;
  logic signed [DW-1:0] src_data;
  logic                 src_valid;
  logic [1:0]           src_error;
  logic                 ovr;

  int  n_tests = 0;
  int  n_fail = 0;
  int  n_valid_seen = 0;
  int  m_out_count = 0;
  bit  m_primed = 1'b0;
  real m_prev = 0.0;

  fm_phase_discriminator #(
    .DATA_WIDTH  (DW),
    .PHASE_WIDTH (PW),
    .ITERATIONS  (N)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ast_sink_i       (sink_i),
    .ast_sink_q       (sink_q),
    .ast_sink_valid   (sink_valid),
    .ast_sink_error   (sink_error),
    .ast_source_data  (src_data),
    .ast_source_valid (src_valid),
    .ast_source_error (src_error),
    .overrun          (ovr)
  );

  always #5 clk = ~clk;

  // Every valid cycle counts once; equals the number of outputs if each strobe is 1 cycle.
  always @(negedge clk) if (src_valid) n_valid_seen++;

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = obs - exp;
    if (tol > 0) begin
      d = d & 65535;
      if (d >= 32768) d -= 65536;
    end
    n_tests++;
    if (d > tol || d < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic real phase_of(input int i, input int q);
    return $atan2(real'(q), real'(i)) * 65536.0 / (2.0 * PI);
  endfunction

  // Drive one sample, watch the following cycles, compare with the model.
  task automatic send(input string tag, input int si, input int sq, input logic [1:0] err,
                      input bit dbl, input int gap, input int tol);
    int  nv, pos, got_d, got_e, exp_d;
    bit  zero;
    real d;
    nv = 0; pos = -1; got_d = 0; got_e = 0; exp_d = 0;
    @(negedge clk);
    sink_i = DW'(si);
    sink_q = DW'(sq);
    sink_error = err;
    sink_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= N + 1 + gap; k++) begin
      @(negedge clk);
      if (k == 1 && dbl) begin
        sink_i = ~sink_i;
        sink_error = 2'b01;
      end else begin
        sink_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (src_valid) begin
        nv++;
        pos = k;
        got_d = int'(src_data);
        got_e = int'(src_error);
      end
    end
    zero = (si == 0) && (sq == 0);
    if (m_primed) begin
      if (zero) begin
        exp_d = 0;
      end else begin
        d = phase_of(si, sq) - m_prev;
        while (d >= 32768.0) d -= 65536.0;
        while (d < -32768.0) d += 65536.0;
        exp_d = rnd(d);
      end
      check({tag, "/count"}, nv, 1, 0);
      check({tag, "/lat"}, pos, N + 1, 0);
      check({tag, "/data"}, got_d, exp_d, tol);
      check({tag, "/err"}, got_e, int'(err), 0);
      m_out_count++;
    end else begin
      check({tag, "/suppr"}, nv, 0, 0);
      m_primed = 1'b1;
    end
    if (!zero) m_prev = phase_of(si, sq);
  endtask

  initial begin
    int  nv;
    real a, r;
    int  ci, cq;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst/valid", int'(src_valid), 0, 0);
    check("rst/data", int'(src_data), 0, 0);
    check("rst/err", int'(src_error), 0, 0);
    check("rst/ovr", int'(ovr), 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: constant vector, spacing 20
    for (int k = 0; k < 4; k++) send("t1", 16384, 0, 2'b00, 1'b0, 2, 2);

    // 2: phasor advancing pi/8 per sample, minimum spacing
    for (int k = 0; k < 9; k++) begin
      a = real'(k) * PI / 8.0;
      send("t2", rnd(16384.0 * $cos(a)), rnd(16384.0 * $sin(a)), 2'b00, 1'b0, 0, 2);
    end

    // 3: wrap across +/-pi in both directions
    send("t3a", -11585, 11585, 2'b00, 1'b0, 1, 2);
    send("t3b", -11585, -11585, 2'b00, 1'b0, 1, 2);
    send("t3c", -11585, 11585, 2'b00, 1'b0, 1, 2);

    // 4: quadrant walk and full-scale corners
    send("t4a", 16384, 0, 2'b00, 1'b0, 0, 2);
    send("t4b", 0, 16384, 2'b00, 1'b0, 0, 2);
    send("t4c", -16384, 0, 2'b00, 1'b0, 0, 2);
    send("t4d", 0, -16384, 2'b00, 1'b0, 0, 2);
    send("t4e", 16384, 0, 2'b00, 1'b0, 0, 2);
    send("t4f", -32768, -32768, 2'b00, 1'b0, 0, 2);
    send("t4g", 32767, 32767, 2'b00, 1'b0, 0, 2);

    // 5: back-to-back strobe drops the second sample; tag travels
    check("t5/ovr0", int'(ovr), 0, 0);
    send("t5a", 16384, 0, 2'b10, 1'b1, 1, 2);
    check("t5/ovr1", int'(ovr), 1, 0);
    send("t5b", 0, 16384, 2'b11, 1'b0, 1, 2);
    check("t5/ovr_sticky", int'(ovr), 1, 0);

    // 6: reset for one cycle mid-rotation aborts the sample
    @(negedge clk);
    sink_i = DW'(11585);
    sink_q = DW'(11585);
    sink_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sink_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_primed = 1'b0;
    m_prev = 0.0;
    nv = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk);
      #1;
      if (src_valid) nv++;
    end
    check("t6/novalid", nv, 0, 0);
    check("t6/data", int'(src_data), 0, 0);
    check("t6/ovr", int'(ovr), 0, 0);
    send("t6a", 0, 16384, 2'b00, 1'b0, 1, 2);
    send("t6b", 0, 0, 2'b01, 1'b0, 1, 2);
    send("t6c", 16384, 0, 2'b00, 1'b0, 1, 2);

    // Randomized vectors over all angles and a range of amplitudes
    for (int k = 0; k < 24; k++) begin
      a = real'($urandom_range(0, 35999)) / 36000.0 * 2.0 * PI;
      r = real'($urandom_range(8000, 30000));
      ci = rnd(r * $cos(a));
      cq = rnd(r * $sin(a));
      send("rand", ci, cq, 2'($urandom_range(0, 3)), 1'b0, int'($urandom_range(0, 3)), 4);
    end

    repeat (3) @(negedge clk);
    check("valid_width", n_valid_seen, m_out_count, 0);
    check("ovr_final", int'(ovr), 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
